// File: rtl/nandgame_mem_unit_if.sv
// nandgame_mem_unit_if: command handshake and A/D/*A operand bus of the memory unit.
interface nandgame_mem_unit_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] x;
  logic [2:0]        write;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] a_mem_reg;
  logic              a_mem_valid;
  logic              a_oob;
  modport master (output x, write, in_valid, input in_ready, a_reg, d_reg, a_mem_reg, a_mem_valid, a_oob);
  modport slave (input x, write, in_valid, output in_ready, a_reg, d_reg, a_mem_reg, a_mem_valid, a_oob);
endinterface

// File: rtl/nandgame_mem_unit.sv
// nandgame_mem_unit: A/D registers plus A-addressed RAM with handshake, read latency,
// *A write forwarding, out-of-range guarding and an optional RAM clear after reset.
module nandgame_mem_unit #(
  parameter int DATA_W         = 16,
  parameter int MEM_SIZE       = 4096,
  parameter int ADDR_W         = $clog2(MEM_SIZE),
  parameter int READ_LAT       = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  nandgame_mem_unit_if.slave    s
);
  localparam int LAT_W = $clog2(READ_LAT) + 1;
  localparam logic [DATA_W:0] MEM_LIM = (DATA_W+1)'(MEM_SIZE);
  typedef enum logic [1:0] {S_CLEAR, S_REFRESH, S_IDLE} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_a, r_d, r_amem;
  logic                r_valid;
  logic [DATA_W-1:0]   r_mem [MEM_SIZE];
  logic                w_oob, w_acc, w_clr_last, w_lat_last;
  logic [ADDR_W-1:0]   w_idx;
  logic [DATA_W-1:0]   w_rd;
  assign w_oob      = {1'b0, r_a} >= MEM_LIM;
  assign w_idx      = r_a[ADDR_W-1:0];
  assign w_rd       = w_oob ? '0 : r_mem[w_idx];
  assign w_acc      = s.in_valid & (r_state == S_IDLE);
  assign w_clr_last = r_clr_cnt == ADDR_W'(MEM_SIZE - 1);
  assign w_lat_last = r_lat_cnt == LAT_W'(READ_LAT - 1);
  assign s.in_ready    = r_state == S_IDLE;
  assign s.a_reg       = r_a;
  assign s.d_reg       = r_d;
  assign s.a_mem_reg   = r_amem;
  assign s.a_mem_valid = r_valid;
  assign s.a_oob       = w_oob;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_REFRESH;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_CLEAR   ? (w_clr_last ? S_REFRESH : S_CLEAR) :
             r_state == S_REFRESH ? (w_lat_last ? S_IDLE : S_REFRESH) :
             (w_acc & s.write[2]) ? S_REFRESH : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clr_cnt <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_state == S_REFRESH) r_lat_cnt <= w_lat_last ? '0 : r_lat_cnt + 1'b1;
    end
  // RAM has no reset; the enable is gated so nothing lands while rst is high
  always_ff @(posedge clk)
    if (!rst) begin
      if (r_state == S_CLEAR) r_mem[r_clr_cnt] <= '0;
      else if (w_acc & s.write[0] & !w_oob) r_mem[w_idx] <= s.x;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a     <= '0;
      r_d     <= '0;
      r_amem  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == S_REFRESH && w_lat_last) begin
        r_amem  <= w_rd;
        r_valid <= 1'b1;
      end
      if (w_acc) begin
        if (s.write[1]) r_d <= s.x;
        if (s.write[2]) begin
          r_a     <= s.x;
          r_valid <= 1'b0;
        end else if (s.write[0]) r_amem <= w_oob ? '0 : s.x;
      end
    end
endmodule

// File: tb/tb_nandgame_mem_unit.sv
// tb_nandgame_mem_unit: directed and random commands checked against an array-based model.
module tb_nandgame_mem_unit;
  localparam int MEM = 4096;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] m_ram [MEM];
  logic [15:0] m_a, m_d, m_amem;
  logic        m_valid;
  nandgame_mem_unit_if #(.DATA_W(16)) bus();
  nandgame_mem_unit #(.DATA_W(16), .MEM_SIZE(MEM), .READ_LAT(LAT), .CLEAR_ON_RESET(1))
    dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < MEM; i++) m_ram[i] = '0;
    m_a = '0; m_d = '0; m_amem = '0; m_valid = 1'b1;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".a"}, {16'h0, bus.a_reg}, {16'h0, m_a});
    chk({tag, ".d"}, {16'h0, bus.d_reg}, {16'h0, m_d});
    chk({tag, ".amem"}, {16'h0, bus.a_mem_reg}, {16'h0, m_amem});
    chk({tag, ".valid"}, {31'h0, bus.a_mem_valid}, {31'h0, m_valid});
    chk({tag, ".oob"}, {31'h0, bus.a_oob}, {31'h0, 1'(int'(m_a) >= MEM)});
    chk({tag, ".ready"}, {31'h0, bus.in_ready}, 32'd1);
  endtask
  // counts busy cycles while poking junk commands that must be ignored
  task automatic wait_busy(input int exp, input string tag);
    int busy = 0;
    while (!bus.in_ready && busy < 10000) begin
      bus.in_valid = 1'b1;
      bus.x = 16'($urandom);
      bus.write = 3'b111;
      @(negedge clk);
      bus.in_valid = 1'b0;
      busy++;
    end
    chk(tag, busy, exp);
  endtask
  task automatic cmd(input logic [15:0] xv, input logic [2:0] wv, input string tag);
    bus.x = xv; bus.write = wv; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (wv[0] && int'(m_a) < MEM) m_ram[m_a[11:0]] = xv;
    if (wv[1]) m_d = xv;
    if (wv[2]) begin
      m_a = xv;
      chk({tag, ".drop"}, {31'h0, bus.a_mem_valid}, 32'd0);
      wait_busy(LAT, {tag, ".lat"});
      m_amem = int'(m_a) < MEM ? m_ram[m_a[11:0]] : 16'h0;
    end else if (wv[0]) m_amem = int'(m_a) < MEM ? xv : 16'h0;
    check_all(tag);
  endtask
  function automatic logic [15:0] pick_addr();
    int r = $urandom_range(0, 9);
    return r < 5 ? 16'($urandom_range(0, 15)) : r == 5 ? 16'hFFF : r == 6 ? 16'(4096 + $urandom_range(0, 4)) : 16'($urandom);
  endfunction
  task automatic rand_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0] w = 3'($urandom_range(0, 7));
      cmd(w[2] ? pick_addr() : 16'($urandom), w, "rnd");
    end
  endtask
  initial begin
    bus.x = '0; bus.write = '0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_busy(MEM + LAT, "boot_lat");
    check_all("boot");
    cmd(16'h0010, 3'b100, "a10");
    cmd(16'hBEEF, 3'b011, "fwd");
    cmd(16'h0010, 3'b100, "a10b");
    cmd(16'h0020, 3'b111, "all");
    cmd(16'h0010, 3'b100, "a10c");
    cmd(16'h1000, 3'b100, "oob");
    cmd(16'h1234, 3'b001, "oobw");
    cmd(16'h0000, 3'b100, "a0");
    cmd(16'h0000, 3'b000, "nop");
    rand_cmds(300);
    cmd(16'h0000, 3'b100, "a0b");
    cmd(16'h5A5A, 3'b001, "r0");
    bus.x = 16'h0005; bus.write = 3'b110; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.a", {16'h0, bus.a_reg}, 32'h0);
    chk("arst.d", {16'h0, bus.d_reg}, 32'h0);
    chk("arst.amem", {16'h0, bus.a_mem_reg}, 32'h0);
    chk("arst.valid", {31'h0, bus.a_mem_valid}, 32'h0);
    chk("arst.ready", {31'h0, bus.in_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_busy(MEM + LAT, "reboot_lat");
    check_all("reboot");
    rand_cmds(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nandgame_mem_unit.md
Name: nandgame_mem_unit

Overview:
Parametrised A/D/memory register unit for the nandgame core. It holds the A register, the D register and a data RAM addressed by A, and presents the *A operand (a_mem_reg) to the ALU. It extends the single-cycle unit with:
- a valid/ready command handshake;
- configurable RAM read latency;
- write-to-*A forwarding;
- out-of-range address handling;
- an optional RAM-clear sequence after reset.

Parameters:
DATA_W, 16, width of x, A, D and RAM words
MEM_SIZE, 4096, number of RAM words; valid range 2..2^DATA_W
ADDR_W, $clog2(MEM_SIZE), RAM index width
READ_LAT, 2, cycles from a refresh request to *A valid; must be >=1
CLEAR_ON_RESET, 1, when 1, zero the whole RAM after reset release

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
x  in  DATA_W  write data (ALU result)
write  in  3  destination select: [0]=*A (RAM), [1]=D, [2]=A
in_valid  in  1  command (x, write) present
in_ready  out  1  unit can accept a command; high only in IDLE
a_reg  out  DATA_W  A register
d_reg  out  DATA_W  D register
a_mem_reg  out  DATA_W  RAM[A] operand
a_mem_valid  out  1  a_mem_reg reflects current RAM[a_reg]
a_oob  out  1  combinational; a_reg >= MEM_SIZE

Behaviour:
- Reset (rst=1, asynchronous):
  - a_reg, d_reg and a_mem_reg go to 0; a_mem_valid goes to 0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else REFRESH.
  - Counters go to 0. RAM contents are not reset asynchronously.
  - Reset asserted in any state aborts the operation in progress; no partial write completes after rst rises.
- States:
  - CLEAR: one RAM word per cycle, RAM[clr_cnt] <= 0, clr_cnt counts 0..MEM_SIZE-1. After the write to MEM_SIZE-1, go to REFRESH.
  - REFRESH: lat_cnt counts READ_LAT cycles. On the edge ending the last cycle: a_mem_reg <= (a_oob ? 0 : RAM[a_reg]), a_mem_valid <= 1, go to IDLE.
  - IDLE: in_ready=1. A command is accepted on any edge where in_valid & in_ready.
- Accept edge (all writes commit on that edge; the RAM write uses the pre-update A):
  - write[0] and !a_oob: RAM[a_reg_old] <= x. If a_oob, the RAM write is silently dropped.
  - write[1]: d_reg <= x.
  - write[2]: a_reg <= x.
- *A update after accept:
  - write[2]=1: a_mem_valid <= 0 and go to REFRESH. The refresh reads the new A and sees the just-written data when new A equals old A.
  - write[2]=0, write[0]=1: forwarding path, no busy time. a_mem_reg <= (a_oob ? 0 : x), a_mem_valid stays 1, stay IDLE.
  - write[2]=0, write[0]=0: a_mem_reg unchanged, stay IDLE. Covers D-only writes and write=0, which is an accepted no-op.
- Latency:
  - A-write accept at edge t: a_mem_valid rises after edge t+READ_LAT; in_ready is low for exactly READ_LAT cycles.
  - After reset release: CLEAR takes MEM_SIZE cycles, then REFRESH takes READ_LAT cycles.
- Handshake rules:
  - in_valid is ignored while in_ready=0; no command is queued.
  - The source must hold x and write stable until accepted.
- Arithmetic: the RAM index is a_reg[ADDR_W-1:0], used only when a_oob=0. No wrap-around: an out-of-range A never aliases onto a low address.
- a_oob is combinational from a_reg and is valid in every state.

Test Plan:
- Reset release, default parameters: in_ready=0 for 4096+2 cycles. Then in_ready=1, a_reg=0, d_reg=0, a_mem_reg=0x0000, a_mem_valid=1.
- A-write x=0x0010, write=3'b100: a_reg=0x0010; a_mem_valid=0 and in_ready=0 for 2 cycles; then a_mem_reg=0x0000, a_mem_valid=1.
- Then x=0xBEEF, write=3'b011: next edge d_reg=0xBEEF, a_mem_reg=0xBEEF; in_ready stays 1. Rewriting A=0x0010 refreshes a_mem_reg to 0xBEEF.
- With A=0x0010, x=0x0020, write=3'b111: RAM[0x10]=0x0020, a_reg=d_reg=0x0020, refreshed a_mem_reg=0x0000. Writing A=0x0010 then refreshes a_mem_reg to 0x0020.
- Out-of-range: MEM_SIZE=4096, A=0x1000 -> a_oob=1, a_mem_reg=0. Write=3'b001 x=0x1234 -> RAM[0x000] unchanged and a_mem_reg stays 0.
- Async reset pulsed mid-REFRESH: a_reg, d_reg, a_mem_reg become 0 and a_mem_valid=0 before the next clk edge. CLEAR restarts from address 0, and no stale refresh completes.
